// File: rtl/pe_psum_binarizer.sv
// pe_psum_binarizer
//
// Accumulates ACC_LEN partial sums per output neuron and compares each total
// against an unsigned threshold. The resulting bits are packed nine at a time
// into an activation word for the next layer's PE.
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-low reset
//   psum_valid_in   psum_in carries a sample
//   psum_in         partial sum from the PE (unsigned, PSUM_W bits)
//   psum_ready_out  block takes a sample this cycle
//   threshold_in    binarization threshold, read only on a neuron's last sample
//   clear_in        synchronous flush of the partial neuron and partial word
//   act_valid_out   activation_out holds a complete word
//   act_ready_in    downstream takes the word
//   activation_out  packed activations, neuron k of the word at bit k
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The sender holds its data stable while valid && !ready, and ready may
// only depend on the receiver's registered state and the partner's ready, never
// on the partner's data.
module pe_psum_binarizer #(
    parameter int ACC_LEN = 4,
    parameter int PSUM_W  = 7,
    parameter int ACC_W   = 10
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              psum_valid_in,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              psum_ready_out,
    input  logic [ACC_W-1:0]  threshold_in,
    input  logic              clear_in,
    output logic              act_valid_out,
    input  logic              act_ready_in,
    output logic [8:0]        activation_out
);

    localparam int              CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    // Only neurons 0..7 are held here; neuron 8 goes straight into the word.
    logic [7:0]       pack;
    logic [3:0]       bit_cnt;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic             last_sample;
    logic             last_bit;
    logic             accept;
    logic             neuron_bit;
    logic             word_load;

    // One extra bit catches the carry so the sum can clamp instead of wrapping.
    assign sum_wide    = {1'b0, acc} + {{(ACC_W + 1 - PSUM_W){1'b0}}, psum_in};
    assign sum_sat     = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign neuron_bit  = (sum_sat >= threshold_in);

    assign last_sample = (acc_cnt == CNT_LAST);
    assign last_bit    = (bit_cnt == 4'd8);

    // Only the sample that would finish a word has to wait for the output
    // register; acc_cnt/bit_cnt are registers, so this path is combinational
    // from act_ready_in alone.
    assign psum_ready_out = !(act_valid_out && !act_ready_in && last_sample && last_bit);
    assign accept         = psum_valid_in && psum_ready_out;

    // A clear on the same edge discards the sample, so no word can be formed.
    assign word_load      = accept && last_sample && last_bit && !clear_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc            <= '0;
            acc_cnt        <= '0;
            pack           <= '0;
            bit_cnt        <= '0;
            act_valid_out  <= 1'b0;
            activation_out <= '0;
        end else begin
            // Drain first; a load on the same edge overrides it (no bubble).
            if (act_valid_out && act_ready_in) begin
                act_valid_out <= 1'b0;
            end
            if (word_load) begin
                act_valid_out  <= 1'b1;
                activation_out <= {neuron_bit, pack};
            end

            if (clear_in) begin
                acc     <= '0;
                acc_cnt <= '0;
                pack    <= '0;
                bit_cnt <= '0;
            end else if (accept) begin
                if (!last_sample) begin
                    acc     <= sum_sat;
                    acc_cnt <= acc_cnt + 1'b1;
                end else begin
                    acc     <= '0;
                    acc_cnt <= '0;
                    if (!last_bit) begin
                        pack[bit_cnt[2:0]] <= neuron_bit;
                        bit_cnt            <= bit_cnt + 1'b1;
                    end else begin
                        pack    <= '0;
                        bit_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_psum_binarizer.sv
// Directed testbench for pe_psum_binarizer.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
// Expected words are pushed into exp_q as the completing sample is accepted
// and popped when the DUT hands a word over.
module tb_pe_psum_binarizer;

    logic       clk_in;
    logic       rst_in;
    logic       psum_valid_in;
    logic [6:0] psum_in;
    logic       psum_ready_out;
    logic [9:0] threshold_in;
    logic       clear_in;
    logic       act_valid_out;
    logic       act_ready_in;
    logic [8:0] activation_out;

    // Second instance with a deliberately narrow accumulator to force clamping.
    logic       s_psum_valid;
    logic [6:0] s_psum;
    logic       s_psum_ready;
    logic [7:0] s_threshold;
    logic       s_clear;
    logic       s_act_valid;
    logic       s_act_ready;
    logic [8:0] s_activation;

    pe_psum_binarizer #(.ACC_LEN(4), .PSUM_W(7), .ACC_W(10)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .psum_valid_in  (psum_valid_in),
        .psum_in        (psum_in),
        .psum_ready_out (psum_ready_out),
        .threshold_in   (threshold_in),
        .clear_in       (clear_in),
        .act_valid_out  (act_valid_out),
        .act_ready_in   (act_ready_in),
        .activation_out (activation_out)
    );

    pe_psum_binarizer #(.ACC_LEN(4), .PSUM_W(7), .ACC_W(8)) dut_sat (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .psum_valid_in  (s_psum_valid),
        .psum_in        (s_psum),
        .psum_ready_out (s_psum_ready),
        .threshold_in   (s_threshold),
        .clear_in       (s_clear),
        .act_valid_out  (s_act_valid),
        .act_ready_in   (s_act_ready),
        .activation_out (s_activation)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard / bookkeeping ----------------
    logic [8:0] exp_q[$];
    int         n_checks;
    int         n_errors;
    logic       obs_ready;
    logic       obs_valid;
    logic [8:0] obs_act;
    logic [8:0] last_popped;
    int         n_popped;
    int         vcount;
    logic       first_valid;

    // Reference model state (ACC_LEN=4, ACC_W=10)
    int         m_acc;
    int         m_cnt;
    logic [8:0] m_pack;
    int         m_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_cnt  = 0;
        m_pack = '0;
        m_bit  = 0;
    endtask

    task automatic model_accept(input logic [6:0] p, input logic [9:0] thr);
        int   s;
        logic b;
        s = m_acc + int'(p);
        if (s > 1023) s = 1023;
        if (m_cnt < 3) begin
            m_acc = s;
            m_cnt++;
        end else begin
            b     = (s >= int'(thr));
            m_acc = 0;
            m_cnt = 0;
            m_pack[m_bit] = b;
            if (m_bit == 8) begin
                exp_q.push_back(m_pack);
                m_pack = '0;
                m_bit  = 0;
            end else begin
                m_bit++;
            end
        end
    endtask

    // One clock of stimulus on the main DUT.
    task automatic step(input logic v, input logic [6:0] p, input logic [9:0] thr,
                        input logic rdy, input logic clr, output logic acc_o);
        logic [8:0] e;
        @(negedge clk_in);
        psum_valid_in = v;
        psum_in       = p;
        threshold_in  = thr;
        act_ready_in  = rdy;
        clear_in      = clr;
        #1;
        obs_ready = psum_ready_out;
        obs_valid = act_valid_out;
        obs_act   = activation_out;
        acc_o     = v && obs_ready;
        if (obs_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {23'd0, obs_act}, 32'h0DEAD);
            end else begin
                e = exp_q.pop_front();
                chk("word", {23'd0, obs_act}, {23'd0, e});
                last_popped = obs_act;
                n_popped++;
            end
        end
        if (clr) model_reset();
        else if (acc_o) model_accept(p, thr);
        @(posedge clk_in);
    endtask

    task automatic send_sample(input logic [6:0] p, input logic [9:0] thr, input logic rdy);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) step(1'b1, p, thr, rdy, 1'b0, a);
        if (!a) chk("sample_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_neuron(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                               input logic [6:0] d, input logic [9:0] thr, input logic rdy);
        send_sample(a, thr, rdy);
        send_sample(b, thr, rdy);
        send_sample(c, thr, rdy);
        send_sample(d, thr, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic a;
        vcount = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 7'd0, 10'd0, rdy, 1'b0, a);
            if (i == 0) first_valid = obs_valid;
            if (obs_valid) vcount++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic a;
        int   stalls;
        int   pops_before;

        n_checks = 0; n_errors = 0; n_popped = 0;
        last_popped = '0;
        rst_in = 1'b0;
        psum_valid_in = 1'b0; psum_in = '0; threshold_in = '0;
        clear_in = 1'b0; act_ready_in = 1'b0;
        s_psum_valid = 1'b0; s_psum = '0; s_threshold = '0;
        s_clear = 1'b0; s_act_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_valid", {31'd0, act_valid_out}, 32'd0);
        chk("rst_act",   {23'd0, activation_out}, 32'd0);
        chk("rst_ready", {31'd0, psum_ready_out}, 32'd1);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Async reset mid-word with a pending word
        for (int n = 0; n < 9; n++) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b0);
        for (int n = 0; n < 3; n++) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b0);
        send_sample(7'd9, 10'd18, 1'b0);
        send_sample(7'd9, 10'd18, 1'b0);
        #3;
        chk("pre_rst_pending", {31'd0, act_valid_out}, 32'd1);
        rst_in = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, act_valid_out}, 32'd0);
        chk("async_rst_act",   {23'd0, activation_out}, 32'd0);
        chk("async_rst_ready", {31'd0, psum_ready_out}, 32'd1);
        psum_valid_in = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int n = 0; n < 9; n++) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b1);
        idle(3, 1'b1);
        chk("post_rst_word", {23'd0, last_popped}, 32'h1FF);

        // Packing order, latency and single-cycle valid
        for (int n = 0; n < 9; n++) begin
            if (n % 2 == 0) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b1);
            else            send_neuron(7'd0, 7'd0, 7'd0, 7'd0, 10'd18, 1'b1);
        end
        idle(4, 1'b1);
        chk("pack_latency",  {31'd0, first_valid}, 32'd1);
        chk("pack_valid_1c", vcount, 32'd1);
        chk("pack_word",     {23'd0, last_popped}, 32'h155);

        // Threshold tie
        for (int n = 0; n < 9; n++)
            send_neuron(7'd5, 7'd5, 7'd5, 7'd3, (n % 2 == 0) ? 10'd18 : 10'd19, 1'b1);
        idle(3, 1'b1);
        chk("tie_word", {23'd0, last_popped}, 32'h155);

        // Backpressure across two words
        stalls = 0;
        for (int n = 0; n < 9; n++) begin
            if (n % 2 == 0) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b0);
            else            send_neuron(7'd0, 7'd0, 7'd0, 7'd0, 10'd18, 1'b0);
        end
        for (int i = 37; i <= 71; i++) begin
            step(1'b1, 7'd9, 10'd18, 1'b0, 1'b0, a);
            if (!a) stalls++;
        end
        chk("bp_no_early_stall", stalls, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'd9, 10'd18, 1'b0, 1'b0, a);
            chk("bp_ready_low", {31'd0, obs_ready}, 32'd0);
            chk("bp_hold",      {23'd0, obs_act},   32'h155);
        end
        pops_before = n_popped;
        step(1'b1, 7'd9, 10'd18, 1'b1, 1'b0, a);
        chk("bp_stalled_accept", {31'd0, a}, 32'd1);
        chk("bp_word1", {23'd0, last_popped}, 32'h155);
        step(1'b0, 7'd0, 10'd0, 1'b1, 1'b0, a);
        chk("bp_no_bubble", {31'd0, obs_valid}, 32'd1);
        chk("bp_word2", {23'd0, obs_act}, 32'h1FF);
        chk("bp_pops", n_popped - pops_before, 32'd2);
        idle(2, 1'b1);

        // Clear with a pending word
        for (int n = 0; n < 9; n++) begin
            if (n % 2 == 0) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b0);
            else            send_neuron(7'd0, 7'd0, 7'd0, 7'd0, 10'd18, 1'b0);
        end
        for (int n = 0; n < 5; n++) send_neuron(7'd9, 7'd9, 7'd9, 7'd9, 10'd18, 1'b0);
        send_sample(7'd9, 10'd18, 1'b0);
        send_sample(7'd9, 10'd18, 1'b0);
        step(1'b1, 7'd9, 10'd18, 1'b0, 1'b1, a);
        step(1'b0, 7'd0, 10'd0, 1'b1, 1'b0, a);
        chk("clr_pending_valid", {31'd0, obs_valid}, 32'd1);
        chk("clr_pending_word",  {23'd0, obs_act},   32'h155);
        for (int n = 0; n < 9; n++) send_neuron(7'd127, 7'd127, 7'd127, 7'd127, 10'd18, 1'b1);
        idle(3, 1'b1);
        chk("clr_next_word", {23'd0, last_popped}, 32'h1FF);
        chk("clr_one_word", vcount, 32'd1);

        // Saturation on the narrow instance
        stalls = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk_in);
            s_psum_valid = 1'b1;
            s_psum       = 7'd127;
            s_threshold  = 8'd255;
            #1;
            if (!s_psum_ready) stalls++;
            @(posedge clk_in);
        end
        @(negedge clk_in);
        s_psum_valid = 1'b0;
        #1;
        chk("sat_no_stall", stalls, 32'd0);
        chk("sat_valid", {31'd0, s_act_valid}, 32'd1);
        chk("sat_word",  {23'd0, s_activation}, 32'h1FF);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_psum_binarizer.md
# pe_psum_binarizer

Consumer of the PE partial-sum stream: it accumulates a fixed number of 7-bit `psum` samples per output neuron and binarizes each total against a threshold. It packs nine binarized neurons into a 9-bit activation word, which is the format the next layer's PE takes on `activation_in`. The block sits between a PE column's `psum_out` and the activation buffer of the next layer. Words leave through a valid/ready handshake.

## Interface
Parameters:
- `ACC_LEN`, default 4: number of `psum` samples summed per neuron (≥1).
- `PSUM_W`, default 7: width of the incoming partial sum.
- `ACC_W`, default 10: accumulator and threshold width. Must satisfy 2^ACC_W−1 ≥ ACC_LEN·(2^PSUM_W−1).

Ports:
- `clk_in` input 1: single clock, rising edge.
- `rst_in` input 1: reset, asynchronous, active-low.
- `psum_valid_in` input 1: `psum_in` holds a valid sample.
- `psum_in` input PSUM_W: partial sum from the PE.
- `psum_ready_out` output 1: block accepts a sample this cycle.
- `threshold_in` input ACC_W: binarization threshold, unsigned.
- `clear_in` input 1: synchronous flush of the partial neuron and partial word.
- `act_valid_out` output 1: `activation_out` holds a complete word.
- `act_ready_in` input 1: downstream accepts the word.
- `activation_out` output 9: packed binary activations; neuron k of the word is at bit k.

## Operation
- A sample is accepted when `psum_valid_in && psum_ready_out` on a rising edge.
- Internal state:
  - `acc`: ACC_W-bit accumulator.
  - `acc_cnt`: 0..ACC_LEN−1.
  - `pack`: 9-bit packing register.
  - `bit_cnt`: 0..8.
  - Output register `activation_out` with `act_valid_out`.
- Accept, when `acc_cnt < ACC_LEN−1`: `acc <= acc + psum_in` (zero-extended, unsigned) and `acc_cnt++`.
- Completing accept, when `acc_cnt == ACC_LEN−1`:
  - `sum = acc + psum_in`.
  - `bit = (sum >= threshold_in)`; ties give 1.
  - `pack[bit_cnt] <= bit`.
  - `acc <= 0`, `acc_cnt <= 0`.
  - If `bit_cnt < 8`, then `bit_cnt++`.
  - If `bit_cnt == 8`, the word {bit, pack[7:0]} loads into the output register, `act_valid_out <= 1`, and `pack <= 0`, `bit_cnt <= 0`.
- `threshold_in` is sampled only on a completing accept and may change between neurons.
- Output handshake:
  - The word is held stable while `act_valid_out && !act_ready_in`.
  - On `act_valid_out && act_ready_in`, `act_valid_out` drops next cycle unless a new word loads on that same edge.
  - If a new word loads on the same edge, `act_valid_out` stays 1 and `activation_out` takes the new word.
- Backpressure: `psum_ready_out = !(act_valid_out && !act_ready_in && acc_cnt==ACC_LEN−1 && bit_cnt==8)`, combinational.
  - Only a word-completing sample is stalled.
  - Partial accumulation continues during a stall.
- `clear_in`:
  - On a rising edge with `clear_in=1`: `acc`, `acc_cnt`, `pack` and `bit_cnt` go to 0.
  - Any sample accepted that same cycle is discarded.
  - The output register and `act_valid_out` are unaffected.
- Saturation: if `acc + psum_in` would exceed 2^ACC_W−1, `acc` clamps to all-ones. A legal parameter choice never saturates.

## Timing
- Reset (`rst_in`=0, asynchronous, any time including mid-word or mid-stall):
  - `act_valid_out=0`, `activation_out=0`.
  - `acc=0`, `acc_cnt=0`, `pack=0`, `bit_cnt=0`.
  - `psum_ready_out=1` results combinationally from the cleared state.
- Latency: `act_valid_out` rises 1 cycle after the edge that accepts the final sample of neuron 8.
- Throughput: one sample per cycle; one word per 9·ACC_LEN accepted samples.
- No combinational path from `psum_in` or `threshold_in` to any output.
- `psum_ready_out` depends combinationally on `act_ready_in` only.
- Simultaneous events on one edge:
  - Drain plus new word: the new word appears and no bubble is inserted.
  - Clear plus completing accept: clear wins; no bit is packed and no word is produced.

## Test plan
- Reset: assert `rst_in`=0 asynchronously mid-cycle with 3 bits packed and 2 samples accumulated, then release. Required: all outputs 0 immediately. The next 36 samples of value 9 with threshold 18 produce `activation_out=9'h1FF`.
- Packing order: ACC_LEN=4, threshold 18, `act_ready_in`=1. Neurons alternate between samples (9,9,9,9) (sum 36) and (0,0,0,0), starting with the 36 case. Required: one word 9'h155, with `act_valid_out` high exactly 1 cycle, 1 cycle after the 36th accept.
- Threshold tie: samples 5,5,5,3 (sum 18) with threshold 18 give bit 1; with threshold 19 they give bit 0. Run 9 neurons alternating thresholds 18 and 19, starting with 18. Required: `activation_out=9'h155`.
- Backpressure: hold `act_ready_in`=0 while 2 full words are streamed. Required:
  - `psum_ready_out` goes 0 only while the 72nd sample is presented; samples 37..71 are all accepted.
  - Word 1 is held stable.
  - Raise `act_ready_in`: word 1 transfers, word 2 loads on the same edge with no bubble, and the stalled sample is accepted.
- Clear: after 5 neurons packed and 2 samples into neuron 6, pulse `clear_in`=1 together with a valid sample, then stream 9 all-ones neurons. Required: the pending output word is unchanged, and the next word is 9'h1FF with no residue from the discarded state.
- Saturation: ACC_W=8, ACC_LEN=4, samples 127 ×4, threshold 255. Required: `acc` clamps to 255 and bit = 1.
